// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one EEPROM SPI master between NUM_REQ requester SMs.
// The granted requester's start/command/ready path is muxed through; idle holders are revoked by a watchdog.
module spi_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     start_in,
  input  logic [16*NUM_REQ-1:0]  tx_in,
  input  logic                   spi_rdy,
  output logic                   start_out,
  output logic [15:0]            tx_out,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rdy_out,
  output logic                   timeout,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    DRAIN
  } state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic [IDX_W-1:0]   last, last_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               timeout_next;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               req_k;

  // Round-robin pick: first set request strictly after last, then wrap to 0..last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    winner = last;
    found  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j <= int'(last))) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

  // Datapath is steered purely by the registered one-hot grant, so it is dead outside GRANTED.
  assign req_k     = |(req & gnt);
  assign start_out = |(start_in & gnt);
  assign rdy_out   = gnt & {NUM_REQ{spi_rdy}};
  assign busy      = (state != IDLE);

  always_comb begin
    tx_out = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) tx_out = tx_out | tx_in[16*j +: 16];
    end
  end

  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    last_next    = last;
    cnt_next     = cnt;
    timeout_next = 1'b0;

    unique case (state)
      IDLE: begin
        gnt_next = '0;
        cnt_next = '0;
        if (found && spi_rdy) begin
          gnt_next   = NUM_REQ'(1) << winner;
          last_next  = winner;
          state_next = GRANTED;
        end
      end

      GRANTED: begin
        if (!req_k) begin
          // A start issued as req drops is still forwarded; wait for the master to finish it.
          gnt_next   = '0;
          cnt_next   = '0;
          state_next = (spi_rdy && !start_out) ? IDLE : DRAIN;
        end else if (start_out || !spi_rdy) begin
          cnt_next = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // last keeps the revoked index so it drops to lowest priority next round.
          timeout_next = 1'b1;
          gnt_next     = '0;
          cnt_next     = '0;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DRAIN: begin
        gnt_next = '0;
        cnt_next = '0;
        if (spi_rdy) state_next = IDLE;
      end

      default: begin
        gnt_next   = '0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state   <= state_next;
      gnt     <= gnt_next;
      last    <= last_next;
      cnt     <= cnt_next;
      timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: reset, round-robin order, start muxing, drain, watchdog, rdy gating.
module tb_spi_arbiter;

  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    start_in;
  logic [16*NUM_REQ-1:0] tx_in;
  logic                  spi_rdy;
  logic                  start_out;
  logic [15:0]           tx_out;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rdy_out;
  logic                  timeout;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .start_in  (start_in),
    .tx_in     (tx_in),
    .spi_rdy   (spi_rdy),
    .start_out (start_out),
    .tx_out    (tx_out),
    .gnt       (gnt),
    .rdy_out   (rdy_out),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
  endtask

  int order [4] = '{0, 1, 2, 0};
  logic [15:0] tx_exp [3] = '{16'h0123, 16'h4567, 16'h89AB};

  initial begin
    rst      = 1'b1;
    req      = '0;
    start_in = '0;
    tx_in    = '0;
    spi_rdy  = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(start_out), 32'h0);
    check("rst_tx", 32'(tx_out), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // 1: async reset mid-burst, then re-grant of requester 0.
    req = 3'b001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    tx_in[15:0] = 16'hBEEF;
    start_in    = 3'b001;
    #1;
    check("t1_start_pass", 32'(start_out), 32'h1);
    check("t1_tx_pass", 32'(tx_out), 32'hBEEF);
    rst = 1'b1;
    #1;
    check("t1_rst_gnt", 32'(gnt), 32'h0);
    check("t1_rst_start", 32'(start_out), 32'h0);
    check("t1_rst_tx", 32'(tx_out), 32'h0);
    check("t1_rst_busy", 32'(busy), 32'h0);
    start_in = '0;
    rst = 1'b0;
    tick();
    check("t1_regrant", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("t1_release", 32'(gnt), 32'h0);

    // 2: round-robin order with all three requesting.
    pulse_reset();
    tx_in = {16'h89AB, 16'h4567, 16'h0123};
    req   = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(3'b001 << order[i]));
      check($sformatf("t2_tx%0d", i), 32'(tx_out), 32'(tx_exp[order[i]]));
      start_in = 3'(3'b001 << order[i]);
      #1;
      check($sformatf("t2_start%0d", i), 32'(start_out), 32'h1);
      tick();
      start_in = '0;
      req      = 3'b111 & ~3'(3'b001 << order[i]);
      tick();
      check($sformatf("t2_idle%0d", i), 32'(gnt), 32'h0);
      req = 3'b111;
    end
    req = '0;
    tick();

    // 3: only the granted requester's start reaches the master.
    req = 3'b001;
    tick();
    check("t3_gnt", 32'(gnt), 32'h1);
    tx_in[15:0] = 16'h2100;
    start_in    = 3'b011;
    #1;
    check("t3_start", 32'(start_out), 32'h1);
    check("t3_tx", 32'(tx_out), 32'h2100);
    check("t3_rdy", 32'(rdy_out), 32'h1);
    tick();
    start_in = 3'b010;
    #1;
    check("t3_foreign_start", 32'(start_out), 32'h0);
    start_in = '0;
    req = '0;
    tick();

    // 4: start coincident with req drop, drain while master busy.
    req = 3'b001;
    tick();
    check("t4_gnt", 32'(gnt), 32'h1);
    req      = 3'b010;
    start_in = 3'b001;
    #1;
    check("t4_start", 32'(start_out), 32'h1);
    tick();
    start_in = '0;
    spi_rdy  = 1'b0;
    #1;
    check("t4_drain_gnt", 32'(gnt), 32'h0);
    check("t4_drain_busy", 32'(busy), 32'h1);
    check("t4_drain_rdy", 32'(rdy_out), 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check("t4_hold_busy", 32'(busy), 32'h1);
    check("t4_hold_gnt", 32'(gnt), 32'h0);
    spi_rdy = 1'b1;
    tick();
    check("t4_idle_busy", 32'(busy), 32'h0);
    check("t4_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();

    // 5: watchdog revoke after TIMEOUT idle cycles, revoked requester goes last.
    req = 3'b001;
    tick();
    check("t5_gnt", 32'(gnt), 32'h1);
    req = 3'b101;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      check($sformatf("t5_wait%0d", i), 32'({timeout, gnt}), 32'({1'b0, 3'b001}));
    end
    tick();
    check("t5_timeout", 32'(timeout), 32'h1);
    check("t5_revoked", 32'(gnt), 32'h0);
    check("t5_revoked_busy", 32'(busy), 32'h0);
    tick();
    check("t5_timeout_clear", 32'(timeout), 32'h0);
    check("t5_gnt_req2", 32'(gnt), 32'h4);
    req = 3'b001;
    tick();
    check("t5_req2_done", 32'(gnt), 32'h0);
    tick();
    check("t5_regrant0", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // 6: no grant while the master is not ready.
    spi_rdy = 1'b0;
    req     = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_hold%0d", i), 32'(gnt), 32'h0);
    end
    spi_rdy = 1'b1;
    tick();
    check("t6_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
